// File: rtl/mem_arbiter_rr2.sv
// Two-requester round-robin arbiter in front of a single in-order memory port.
// A small route FIFO remembers which requester owns each outstanding request so
// that responses, which come back in issue order, are steered to their owner.
module mem_arbiter_rr2 #(
   parameter int unsigned p_req_bits     = 32,
   parameter int unsigned p_resp_bits    = 32,
   parameter int unsigned p_max_inflight = 4
) (
   input  logic                              clk,
   input  logic                              rst,

   input  logic [p_req_bits-1:0]             up0_req_msg,
   input  logic                              up0_req_val,
   output logic                              up0_req_rdy,
   output logic [p_resp_bits-1:0]            up0_resp_msg,
   output logic                              up0_resp_val,
   input  logic                              up0_resp_rdy,

   input  logic [p_req_bits-1:0]             up1_req_msg,
   input  logic                              up1_req_val,
   output logic                              up1_req_rdy,
   output logic [p_resp_bits-1:0]            up1_resp_msg,
   output logic                              up1_resp_val,
   input  logic                              up1_resp_rdy,

   output logic [p_req_bits-1:0]             dn_req_msg,
   output logic                              dn_req_val,
   input  logic                              dn_req_rdy,
   input  logic [p_resp_bits-1:0]            dn_resp_msg,
   input  logic                              dn_resp_val,
   output logic                              dn_resp_rdy,

   output logic [$clog2(p_max_inflight):0]   inflight
);

   localparam int unsigned PtrW = $clog2(p_max_inflight);
   localparam int unsigned CntW = PtrW + 1;

   logic                      last_grant_q, last_grant_d;
   logic [p_max_inflight-1:0] route_q, route_d;
   logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]           count_q, count_d;

   logic full, empty, grant, head, req_fire, resp_fire;

   // Request arbitration: lone requester wins, ties alternate against last grant.
   always_comb begin
      full = (count_q == CntW'(p_max_inflight));
      if (up0_req_val && up1_req_val) begin
         grant = ~last_grant_q;
      end else begin
         grant = up1_req_val;
      end
      // Full blocks issue outright; a same-cycle pop does not bypass it.
      dn_req_val  = (up0_req_val | up1_req_val) & ~full;
      dn_req_msg  = grant ? up1_req_msg : up0_req_msg;
      up0_req_rdy = ~grant & dn_req_rdy & ~full;
      up1_req_rdy = grant & dn_req_rdy & ~full;
      req_fire    = dn_req_val & dn_req_rdy;
   end

   // Response steering to the owner recorded at the FIFO head.
   always_comb begin
      empty        = (count_q == '0);
      head         = route_q[rd_ptr_q];
      up0_resp_msg = dn_resp_msg;
      up1_resp_msg = dn_resp_msg;
      up0_resp_val = dn_resp_val & ~empty & ~head;
      up1_resp_val = dn_resp_val & ~empty & head;
      // Never acknowledge a response with no recorded owner (e.g. stale after reset).
      dn_resp_rdy  = ~empty & (head ? up1_resp_rdy : up0_resp_rdy);
      resp_fire    = dn_resp_val & dn_resp_rdy;
   end

   // Next-state for grant history and route FIFO.
   always_comb begin
      last_grant_d = last_grant_q;
      route_d      = route_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      if (req_fire) begin
         last_grant_d      = grant;
         route_d[wr_ptr_q] = grant;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (resp_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({req_fire, resp_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset favours requester 0 on the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         route_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         route_q      <= route_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   assign inflight = count_q;

endmodule

// File: tb/tb_mem_arbiter_rr2.sv
// Bench for mem_arbiter_rr2: queue-based reference model checked every cycle,
// an in-order memory model with configurable delay, per-requester scoreboards,
// and directed scenarios with hand-derived expectations.
module tb_mem_arbiter_rr2;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned IW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [31:0] up0_req_msg, up1_req_msg, up0_resp_msg, up1_resp_msg;
   logic        up0_req_val, up0_req_rdy, up0_resp_val, up0_resp_rdy;
   logic        up1_req_val, up1_req_rdy, up1_resp_val, up1_resp_rdy;
   logic [31:0] dn_req_msg, dn_resp_msg;
   logic        dn_req_val, dn_req_rdy, dn_resp_val, dn_resp_rdy;
   logic [IW-1:0] inflight;

   mem_arbiter_rr2 #(
      .p_req_bits     (32),
      .p_resp_bits    (32),
      .p_max_inflight (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .up0_req_msg  (up0_req_msg),
      .up0_req_val  (up0_req_val),
      .up0_req_rdy  (up0_req_rdy),
      .up0_resp_msg (up0_resp_msg),
      .up0_resp_val (up0_resp_val),
      .up0_resp_rdy (up0_resp_rdy),
      .up1_req_msg  (up1_req_msg),
      .up1_req_val  (up1_req_val),
      .up1_req_rdy  (up1_req_rdy),
      .up1_resp_msg (up1_resp_msg),
      .up1_resp_val (up1_resp_val),
      .up1_resp_rdy (up1_resp_rdy),
      .dn_req_msg   (dn_req_msg),
      .dn_req_val   (dn_req_val),
      .dn_req_rdy   (dn_req_rdy),
      .dn_resp_msg  (dn_resp_msg),
      .dn_resp_val  (dn_resp_val),
      .dn_resp_rdy  (dn_resp_rdy),
      .inflight     (inflight)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] resp;
      int          rdy_cyc;
   } mem_ent_t;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Reference model: owner of every outstanding request, oldest first.
   bit          m_last = 1'b1;
   bit          own_q[$];
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   // Stimulus state.
   bit          rq_val[2];
   logic [31:0] rq_msg[2];
   int          rq_seq[2], rq_left[2], rq_rate[2], rr_rate[2];
   int          mreq_rate, mdel_min, mdel_max;
   mem_ent_t    mem_q[$];

   // Per-phase logs.
   int          grant_log[$], rf_cyc0[$], pop_cyc[$], rx_cyc0[$], rx_cyc1[$];
   logic [31:0] rx_msg0[$];
   int          sent[2], recvd[2], peak;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] mkmsg(input int id, input int seq);
      logic [31:0] m;
      m = 32'(seq * 4);
      m[31] = id[0];
      return m;
   endfunction

   function automatic logic [31:0] respf(input logic [31:0] m);
      return m ^ 32'hDEAD_BEEF;
   endfunction

   function automatic bit roll(input int rate);
      return int'($urandom_range(0, 99)) < rate;
   endfunction

   task automatic drive();
      up0_req_val  = rq_val[0];
      up0_req_msg  = rq_msg[0];
      up1_req_val  = rq_val[1];
      up1_req_msg  = rq_msg[1];
      up0_resp_rdy = roll(rr_rate[0]);
      up1_resp_rdy = roll(rr_rate[1]);
      dn_req_rdy   = roll(mreq_rate);
      if (mem_q.size() > 0 && cyc >= mem_q[0].rdy_cyc) begin
         dn_resp_val = 1'b1;
         dn_resp_msg = mem_q[0].resp;
      end else begin
         dn_resp_val = 1'b0;
         dn_resp_msg = '0;
      end
   endtask

   task automatic start_req(input int id, input int n, input int rate);
      rq_left[id] = n;
      rq_rate[id] = rate;
      rq_seq[id]  = 0;
      rq_msg[id]  = mkmsg(id, 0);
      rq_val[id]  = (n > 0) && roll(rate);
   endtask

   task automatic clr_logs();
      grant_log.delete(); rf_cyc0.delete(); pop_cyc.delete();
      rx_cyc0.delete(); rx_cyc1.delete(); rx_msg0.delete();
      sent[0] = 0; sent[1] = 0; recvd[0] = 0; recvd[1] = 0; peak = 0;
   endtask

   // One clock: compare at negedge, advance model and stimulus at posedge.
   task automatic cycle();
      int n; bit full, empty, h, g, e_dv, e_drr;
      bit a_rf[2], a_pf[2], a_dnf, a_drf;
      logic [31:0] a_pm[2], a_dnmsg, e;
      mem_ent_t ent;
      @(negedge clk);
      n     = own_q.size();
      full  = (n == DEPTH);
      empty = (n == 0);
      h     = empty ? 1'b0 : own_q[0];
      g     = (up0_req_val && up1_req_val) ? !m_last : up1_req_val;
      e_dv  = (up0_req_val || up1_req_val) && !full;
      e_drr = !empty && (h ? up1_resp_rdy : up0_resp_rdy);
      chk("dn_req_val", dn_req_val, e_dv);
      chk("dn_req_msg", dn_req_msg, g ? up1_req_msg : up0_req_msg);
      chk("up0_req_rdy", up0_req_rdy, !g && dn_req_rdy && !full);
      chk("up1_req_rdy", up1_req_rdy, g && dn_req_rdy && !full);
      chk("up0_resp_val", up0_resp_val, dn_resp_val && !empty && !h);
      chk("up1_resp_val", up1_resp_val, dn_resp_val && !empty && h);
      chk("dn_resp_rdy", dn_resp_rdy, e_drr);
      chk("inflight", 32'(inflight), n);
      if (dn_resp_val && !empty && !h) chk("up0_resp_msg", up0_resp_msg, dn_resp_msg);
      if (dn_resp_val && !empty && h)  chk("up1_resp_msg", up1_resp_msg, dn_resp_msg);
      a_rf[0] = up0_req_val && up0_req_rdy;
      a_rf[1] = up1_req_val && up1_req_rdy;
      a_pf[0] = up0_resp_val && up0_resp_rdy;
      a_pf[1] = up1_resp_val && up1_resp_rdy;
      a_pm[0] = up0_resp_msg;
      a_pm[1] = up1_resp_msg;
      a_dnf   = dn_req_val && dn_req_rdy;
      a_dnmsg = dn_req_msg;
      a_drf   = dn_resp_val && dn_resp_rdy;
      if (int'(inflight) > peak) peak = int'(inflight);
      @(posedge clk);
      if (!rst) begin
         if (dn_resp_val && e_drr) void'(own_q.pop_front());
         if (e_dv && dn_req_rdy) begin
            m_last = g;
            own_q.push_back(g);
         end
         if (a_drf) begin
            pop_cyc.push_back(cyc);
            if (mem_q.size() > 0) void'(mem_q.pop_front());
         end
         if (a_dnf) begin
            ent.resp    = respf(a_dnmsg);
            ent.rdy_cyc = cyc + int'($urandom_range(mdel_min, mdel_max));
            mem_q.push_back(ent);
         end
         for (int i = 0; i < 2; i++) begin
            if (a_rf[i]) begin
               if (i == 0) exp_q0.push_back(respf(rq_msg[0]));
               else        exp_q1.push_back(respf(rq_msg[1]));
               if (i == 0) rf_cyc0.push_back(cyc);
               grant_log.push_back(i);
               sent[i]++;
               rq_left[i]--;
               rq_seq[i]++;
               rq_msg[i] = mkmsg(i, rq_seq[i]);
               rq_val[i] = (rq_left[i] > 0) && roll(rq_rate[i]);
            end else if (!rq_val[i]) begin
               rq_val[i] = (rq_left[i] > 0) && roll(rq_rate[i]);
            end
            if (a_pf[i]) begin
               if (i == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hxxxx_xxxx;
               else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hxxxx_xxxx;
               chk(i == 0 ? "up0_resp_order" : "up1_resp_order", a_pm[i], e);
               recvd[i]++;
               if (i == 0) begin
                  rx_cyc0.push_back(cyc);
                  rx_msg0.push_back(a_pm[0]);
               end else begin
                  rx_cyc1.push_back(cyc);
               end
            end
         end
      end
      cyc++;
      #1 drive();
   endtask

   task automatic drain();
      bit done;
      rq_left[0] = 0; rq_left[1] = 0;
      rr_rate[0] = 100; rr_rate[1] = 100; mreq_rate = 100;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         cycle();
         done = own_q.size() == 0 && mem_q.size() == 0 && exp_q0.size() == 0 &&
                exp_q1.size() == 0 && !rq_val[0] && !rq_val[1];
      end
      chk("drain_done", done, 1);
      chk("drain_inflight", 32'(inflight), 0);
   endtask

   initial begin
      rq_val[0] = 0; rq_val[1] = 0; rq_left[0] = 0; rq_left[1] = 0;
      rq_rate[0] = 0; rq_rate[1] = 0; rq_seq[0] = 0; rq_seq[1] = 0;
      rq_msg[0] = '0; rq_msg[1] = '0;
      rr_rate[0] = 100; rr_rate[1] = 100; mreq_rate = 100; mdel_min = 1; mdel_max = 1;
      clr_logs();
      drive();
      #2;
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_dn_req_val", dn_req_val, 0);
      chk("rst_dn_resp_rdy", dn_resp_rdy, 0);
      chk("rst_up0_resp_val", up0_resp_val, 0);
      chk("rst_up1_resp_val", up1_resp_val, 0);
      for (int k = 0; k < 3; k++) cycle();
      rst = 1'b0;

      // Both requesters continuously valid: grants alternate starting with up0.
      clr_logs();
      start_req(0, 4, 100); start_req(1, 4, 100); drive();
      for (int k = 0; k < 40 && (sent[0] + sent[1]) < 8; k++) cycle();
      chk("alt_nsent", sent[0] + sent[1], 8);
      if (grant_log.size() >= 4) begin
         chk("alt_grant0", grant_log[0], 0);
         chk("alt_grant1", grant_log[1], 1);
         chk("alt_grant2", grant_log[2], 0);
         chk("alt_grant3", grant_log[3], 1);
      end
      drain();
      chk("alt_recv0", recvd[0], 4);
      chk("alt_recv1", recvd[1], 4);

      // up0 alone, three back-to-back requests 0x0, 0x4, 0x8, memory delay 2.
      clr_logs();
      mdel_min = 2; mdel_max = 2;
      start_req(0, 3, 100); drive();
      for (int k = 0; k < 50 && recvd[0] < 3; k++) cycle();
      chk("solo_nreq", rf_cyc0.size(), 3);
      if (rf_cyc0.size() == 3) begin
         chk("solo_b2b_1", rf_cyc0[1], rf_cyc0[0] + 1);
         chk("solo_b2b_2", rf_cyc0[2], rf_cyc0[0] + 2);
      end
      chk("solo_nrx", rx_msg0.size(), 3);
      if (rx_msg0.size() == 3) begin
         chk("solo_rx0", rx_msg0[0], 32'hDEAD_BEEF);
         chk("solo_rx1", rx_msg0[1], 32'hDEAD_BEEB);
         chk("solo_rx2", rx_msg0[2], 32'hDEAD_BEE7);
      end
      chk("solo_up1_rx", recvd[1], 0);
      chk("solo_peak", peak, 2);
      drain();

      // FIFO full: 5th request waits until the cycle after the first pop.
      clr_logs();
      mdel_min = 6; mdel_max = 6;
      start_req(0, 5, 100); drive();
      for (int k = 0; k < 60 && sent[0] < 5; k++) cycle();
      chk("stall_nreq", rf_cyc0.size(), 5);
      if (rf_cyc0.size() == 5 && pop_cyc.size() > 0) begin
         chk("stall_fill", rf_cyc0[3], rf_cyc0[0] + 3);
         chk("stall_resume", rf_cyc0[4], pop_cyc[0] + 1);
      end
      chk("stall_peak", peak, DEPTH);
      drain();

      // up1 response at head blocked by its resp_rdy=0; up0's later response waits.
      clr_logs();
      mdel_min = 1; mdel_max = 1;
      rr_rate[1] = 0;
      start_req(1, 1, 100); drive();
      for (int k = 0; k < 20 && sent[1] < 1; k++) cycle();
      start_req(0, 1, 100); drive();
      for (int k = 0; k < 20 && sent[0] < 1; k++) cycle();
      for (int k = 0; k < 6; k++) cycle();
      chk("hold_up1_val", up1_resp_val, 1);
      chk("hold_up0_val", up0_resp_val, 0);
      chk("hold_dn_resp_rdy", dn_resp_rdy, 0);
      chk("hold_nrx", recvd[0] + recvd[1], 0);
      rr_rate[1] = 100;
      for (int k = 0; k < 20 && (recvd[0] + recvd[1]) < 2; k++) cycle();
      chk("hold_rx1", rx_cyc1.size(), 1);
      chk("hold_rx0", rx_cyc0.size(), 1);
      if (rx_cyc0.size() == 1 && rx_cyc1.size() == 1)
         chk("hold_order", rx_cyc0[0], rx_cyc1[0] + 1);
      drain();

      // Reset with two requests outstanding; stale responses must be held off.
      clr_logs();
      mdel_min = 10; mdel_max = 10;
      start_req(0, 2, 100); drive();
      for (int k = 0; k < 20 && sent[0] < 2; k++) cycle();
      chk("mrst_pre_inflight", 32'(inflight), 2);
      #2 rst = 1'b1;
      #1;
      chk("mrst_inflight", 32'(inflight), 0);
      chk("mrst_dn_resp_rdy", dn_resp_rdy, 0);
      chk("mrst_up0_resp_val", up0_resp_val, 0);
      own_q.delete(); exp_q0.delete(); exp_q1.delete(); m_last = 1'b1;
      rq_val[0] = 0; rq_val[1] = 0; rq_left[0] = 0; rq_left[1] = 0;
      drive();
      cycle(); cycle();
      rst = 1'b0;
      for (int k = 0; k < 30 && mem_q.size() > 0 && cyc < mem_q[0].rdy_cyc + 3; k++) cycle();
      chk("stale_val_seen", dn_resp_val, 1);
      chk("stale_dn_resp_rdy", dn_resp_rdy, 0);
      chk("stale_not_acked", mem_q.size(), 2);
      mem_q.delete();
      mdel_min = 1; mdel_max = 1;
      clr_logs();
      start_req(0, 2, 100); start_req(1, 2, 100); drive();
      for (int k = 0; k < 30 && (sent[0] + sent[1]) < 4; k++) cycle();
      chk("mrst_nsent", sent[0] + sent[1], 4);
      if (grant_log.size() > 0) chk("mrst_first_grant", grant_log[0], 0);
      drain();

      // Randomized traffic, memory delays up to 3.
      clr_logs();
      mdel_min = 0; mdel_max = 3;
      start_req(0, 100000, 60); start_req(1, 100000, 60);
      for (int chunk = 0; chunk < 10; chunk++) begin
         rq_rate[0] = int'($urandom_range(20, 100));
         rq_rate[1] = int'($urandom_range(20, 100));
         rr_rate[0] = int'($urandom_range(30, 100));
         rr_rate[1] = int'($urandom_range(30, 100));
         mreq_rate  = int'($urandom_range(30, 100));
         for (int k = 0; k < 200; k++) cycle();
      end
      drain();
      chk("rand_sent0_nonzero", sent[0] > 0, 1);
      chk("rand_sent1_nonzero", sent[1] > 0, 1);
      chk("rand_count0", recvd[0], sent[0]);
      chk("rand_count1", recvd[1], sent[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_rr2.md
Name: mem_arbiter_rr2

Overview:
- Shares one downstream memory interface between two upstream requesters. Typical pairing: BlimpV1 instruction-fetch port and a future data-memory port.
- Arbitration is fair round-robin on the request channel. A route FIFO records which requester owns each in-flight request, and responses are steered back in issue order.
- Sits between the core's MemIntf masters and the memory (MemIntfTestServer in benches).
- Memory responses return in request order; this block depends on that property.

Parameters:
- p_req_bits, 32, width of the request message; passed through unmodified.
- p_resp_bits, 32, width of the response message; passed through unmodified.
- p_max_inflight, 4, route FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- up0_req_msg  input  p_req_bits  requester 0 request
- up0_req_val  input  1  requester 0 request valid
- up0_req_rdy  output  1  requester 0 request ready
- up0_resp_msg  output  p_resp_bits  requester 0 response
- up0_resp_val  output  1  requester 0 response valid
- up0_resp_rdy  input  1  requester 0 response ready
- up1_*  same six signals for requester 1
- dn_req_msg  output  p_req_bits  memory request
- dn_req_val  output  1  memory request valid
- dn_req_rdy  input  1  memory request ready
- dn_resp_msg  input  p_resp_bits  memory response
- dn_resp_val  input  1  memory response valid
- dn_resp_rdy  output  1  memory response ready
- inflight  output  $clog2(p_max_inflight)+1  outstanding request count

Behaviour:
- Handshakes: val/rdy. A transfer ("fire") happens when val and rdy are both high at posedge clk. val must not depend combinationally on rdy.
- State:
  - last_grant (1 bit).
  - Route FIFO of p_max_inflight x 1 bit, with wr_ptr, rd_ptr and count registers.
- Reset (async, asserted): last_grant=1 so requester 0 wins the first tie; FIFO pointers and count go to 0.
- Reset output values: all *_rdy=0 except up*_req_rdy, which follow the grant logic below. All *_val=0. inflight=0.
- Reset mid-operation: in-flight routing is discarded. Any response arriving after reset deasserts with the FIFO empty is held off (dn_resp_rdy=0). Clearing stale memory state is the system's job.
- Request arbitration (combinational, zero latency):
  - full = (count == p_max_inflight).
  - Only one requester valid: it is granted.
  - Both valid: grant = ~last_grant.
  - dn_req_val = (up0_req_val | up1_req_val) & ~full.
  - dn_req_msg = granted requester's message; when neither is valid it is don't-care but deterministic (up0).
  - upN_req_rdy = grantN & dn_req_rdy & ~full. The non-granted requester sees rdy=0.
- On dn request fire: last_grant <= granted ID; the granted ID is pushed to the FIFO; wr_ptr wraps modulo p_max_inflight.
- Full: no request is issued, even if a response pops in the same cycle (no bypass). Issuing resumes the cycle after the pop.
- Response steering:
  - head = FIFO[rd_ptr]; empty = (count==0).
  - up{head}_resp_val = dn_resp_val & ~empty; the other requester's resp_val=0.
  - up{head}_resp_msg = dn_resp_msg. Both resp_msg outputs may carry dn_resp_msg at all times.
  - dn_resp_rdy = ~empty & up{head}_resp_rdy.
  - On response fire: pop, and rd_ptr wraps.
- dn_resp_val while empty is a protocol violation. It is never acknowledged, and the bench flags it.
- Simultaneous push and pop (not full): count is unchanged, both pointers advance.
- inflight = count, registered.
- Latency: 0 cycles added on both request and response paths. Throughput: 1 request and 1 response per cycle.

Test Plan:
- Only up0 sends 3 back-to-back requests, addrs 0x0, 0x4, 0x8; memory always ready → dn_req fires on 3 consecutive cycles. Responses go only to up0, in order. up1_resp_val stays 0. inflight peaks at ≤3 and returns to 0.
- up0 and up1 both valid continuously after reset → grants alternate 0,1,0,1. The first grant is up0. Each response reaches its originator in order.
- p_max_inflight=2, memory response delay 3 cycles, up0 streaming → the 3rd request is stalled (up0_req_rdy=0) while inflight=2. It issues the cycle after the first response pops.
- up1 holds resp_rdy=0 with its response at FIFO head → dn_resp_rdy=0 and up0's later response is blocked. Releasing up1_resp_rdy delivers both in order.
- Reset asserted mid-stream with 2 requests outstanding → outputs clear immediately (async). After reset, inflight=0, dn_resp_rdy=0, and the first grant goes to up0.
- Randomized delays: MemIntfTestServer send/recv interval delays of 3 → every upstream response matches its request address. No dropped or duplicated transactions.
